// File: rtl/xadc_drp_responder_if.sv
// DRP bus between a DRP reader (master) and the XADC stand-in (slave).
// Handshake: the master pulses den_in for one cycle with daddr_in/dwe_in/di_in
// valid in that same cycle; the slave answers with a one-cycle drdy_out, with
// do_out valid only while drdy_out=1. drp_busy_out is high while a
// transaction is outstanding, and any den_in seen during that time is dropped.
interface xadc_drp_responder_if;
   logic [6:0]  daddr_in;
   logic        den_in;
   logic        dwe_in;
   logic [15:0] di_in;
   logic [15:0] do_out;
   logic        drdy_out;
   logic        drp_busy_out;

   modport master (
      output daddr_in, den_in, dwe_in, di_in,
      input  do_out, drdy_out, drp_busy_out
   );

   modport slave (
      input  daddr_in, den_in, dwe_in, di_in,
      output do_out, drdy_out, drp_busy_out
   );
endinterface

// File: rtl/xadc_drp_responder.sv
// XADC stand-in on the DRP: fixed-latency register-file responder plus a
// conversion sequencer that fills the XA1..XA4 result registers from an
// external 12-bit sample source and pulses eoc_out per conversion slot.
// Optional build macro: XADC_RESP_PROTOCOL_CHECK_EN enables the sticky
// protocol_err_out checker; without it protocol_err_out is tied to 0.
module xadc_drp_responder #(
   parameter int RD_LATENCY = 4,    // 1..15
   parameter int EOC_PERIOD = 100   // 2..65535
) (
   input  logic                   clk_100MHz,
   input  logic                   reset_n,
   xadc_drp_responder_if.slave    drp,
   output logic                   eoc_out,
   output logic [4:0]             channel_out,
   input  logic                   sample_valid,
   input  logic [1:0]             sample_ch,
   input  logic [11:0]            sample_data,
   output logic                   protocol_err_out,
   output logic [1:0]             dbg_state_out
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   localparam int             PCW         = (EOC_PERIOD > 1) ? $clog2(EOC_PERIOD) : 1;
   localparam logic [PCW-1:0] PERIOD_LAST = PCW'(EOC_PERIOD - 1);
   localparam logic [3:0]     LAT_LOAD    = 4'(RD_LATENCY - 1);

   // Channel address (low five bits) of result slot idx: 0x16, 0x17, 0x1E, 0x1F.
   function automatic logic [4:0] chan_of(input logic [1:0] idx);
      case (idx)
         2'd0:    chan_of = 5'h16;
         2'd1:    chan_of = 5'h17;
         2'd2:    chan_of = 5'h1E;
         default: chan_of = 5'h1F;
      endcase
   endfunction

   logic [1:0]     state_q, state_d;
   logic [3:0]     lat_cnt_q, lat_cnt_d;
   logic [6:0]     addr_q, addr_d;
   logic           we_q, we_d;
   logic [15:0]    di_q, di_d;
   logic [15:0]    rdata_q, rdata_d;
   logic [15:0]    cfg_q [16];
   logic [11:0]    result_q [4];
   logic [11:0]    shadow_q [4];
   logic [1:0]     idx_q;
   logic [PCW-1:0] per_cnt_q;
   logic           eoc_q;
   logic [4:0]     chan_q;

   logic [15:0]    rd_value;
   logic           addr_is_cfg;
   logic           cfg_commit;
   logic           tc;

   assign addr_is_cfg = (drp.daddr_in[6:4] == 3'b100);
   assign cfg_commit  = (state_q == ST_RESP) && we_q && (addr_q[6:4] == 3'b100);
   assign tc          = (per_cnt_q == PERIOD_LAST);

   // Read mux over the live register file, sampled in the den_in cycle.
   always_comb begin
      rd_value = 16'h0000;
      if (addr_is_cfg) begin
         rd_value = cfg_q[drp.daddr_in[3:0]];
      end
      for (int i = 0; i < 4; i++) begin
         if (drp.daddr_in == {2'b00, chan_of(2'(i))}) begin
            rd_value = {result_q[i], 4'h0};
         end
      end
   end

   // DRP FSM next state: capture in IDLE, count latency in WAIT, answer in RESP.
   always_comb begin
      state_d   = state_q;
      lat_cnt_d = lat_cnt_q;
      addr_d    = addr_q;
      we_d      = we_q;
      di_d      = di_q;
      rdata_d   = rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (drp.den_in) begin
               addr_d  = drp.daddr_in;
               we_d    = drp.dwe_in;
               di_d    = drp.di_in;
               rdata_d = drp.dwe_in ? 16'h0000 : rd_value;
               if (RD_LATENCY == 1) begin
                  state_d = ST_RESP;
               end else begin
                  lat_cnt_d = LAT_LOAD;
                  state_d   = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            lat_cnt_d = lat_cnt_q - 4'd1;
            if (lat_cnt_q == 4'd1) begin
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // DRP FSM and transaction capture registers.
   always_ff @(posedge clk_100MHz or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         lat_cnt_q <= 4'd0;
         addr_q    <= 7'd0;
         we_q      <= 1'b0;
         di_q      <= 16'h0000;
         rdata_q   <= 16'h0000;
      end else begin
         state_q   <= state_d;
         lat_cnt_q <= lat_cnt_d;
         addr_q    <= addr_d;
         we_q      <= we_d;
         di_q      <= di_d;
         rdata_q   <= rdata_d;
      end
   end

   // Configuration registers: a write lands on the edge that ends its RESP cycle.
   always_ff @(posedge clk_100MHz or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 16; i++) begin
            cfg_q[i] <= 16'h0000;
         end
      end else if (cfg_commit) begin
         cfg_q[addr_q[3:0]] <= di_q;
      end
   end

   // Shadow samples track the source every cycle, independent of the DRP side.
   always_ff @(posedge clk_100MHz or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 4; i++) begin
            shadow_q[i] <= 12'h000;
         end
      end else if (sample_valid) begin
         shadow_q[sample_ch] <= sample_data;
      end
   end

   // Conversion sequencer: one result slot per period, with same-cycle bypass.
   always_ff @(posedge clk_100MHz or negedge reset_n) begin
      if (!reset_n) begin
         per_cnt_q <= '0;
         idx_q     <= 2'd0;
         eoc_q     <= 1'b0;
         chan_q    <= 5'h16;
         for (int i = 0; i < 4; i++) begin
            result_q[i] <= 12'h000;
         end
      end else begin
         eoc_q <= tc;
         if (tc) begin
            per_cnt_q <= '0;
            idx_q     <= idx_q + 2'd1;
            chan_q    <= chan_of(idx_q);
            if (sample_valid && (sample_ch == idx_q)) begin
               result_q[idx_q] <= sample_data;
            end else begin
               result_q[idx_q] <= shadow_q[idx_q];
            end
         end else begin
            per_cnt_q <= per_cnt_q + 1'b1;
         end
      end
   end

   assign drp.drdy_out     = (state_q == ST_RESP);
   assign drp.do_out       = (state_q == ST_RESP) ? rdata_q : 16'h0000;
   assign drp.drp_busy_out = (state_q != ST_IDLE);
   assign eoc_out          = eoc_q;
   assign channel_out      = chan_q;
   assign dbg_state_out    = state_q;

`ifdef XADC_RESP_PROTOCOL_CHECK_EN
   logic addr_is_res;
   logic proto_viol;
   logic err_q;

   // Flags strobes to unmapped space, writes to read-only results, and strobes while busy.
   always_comb begin
      addr_is_res = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (drp.daddr_in == {2'b00, chan_of(2'(i))}) begin
            addr_is_res = 1'b1;
         end
      end
      proto_viol = drp.den_in && ((state_q != ST_IDLE) ||
                                  (!addr_is_cfg && !addr_is_res) ||
                                  (drp.dwe_in && addr_is_res));
   end

   // Sticky error flag, cleared only by reset.
   always_ff @(posedge clk_100MHz or negedge reset_n) begin
      if (!reset_n) begin
         err_q <= 1'b0;
      end else if (proto_viol) begin
         err_q <= 1'b1;
      end
   end

   assign protocol_err_out = err_q;
`else
   assign protocol_err_out = 1'b0;
`endif

endmodule

// File: tb/tb_xadc_drp_responder.sv
// Bench for xadc_drp_responder (RD_LATENCY=4, EOC_PERIOD=8): table-driven DRP
// vectors checked through an expected-response queue, plus hand sequences for
// back-to-back strobes, conversion order, bypass and reset mid-transaction.
module tb_xadc_drp_responder;

   localparam int RD_LAT = 4;
   localparam int EOC_P  = 8;
`ifdef XADC_RESP_PROTOCOL_CHECK_EN
   localparam logic ERR_EN = 1'b1;
`else
   localparam logic ERR_EN = 1'b0;
`endif

   typedef struct {
      logic        we;
      logic [6:0]  addr;
      logic [15:0] di;
      logic [15:0] exp_do;
   } vec_t;

   logic        clk_100MHz;
   logic        reset_n;
   logic        eoc_out;
   logic [4:0]  channel_out;
   logic        sample_valid;
   logic [1:0]  sample_ch;
   logic [11:0] sample_data;
   logic        protocol_err_out;
   logic [1:0]  dbg_state_out;

   xadc_drp_responder_if drp_if ();

   xadc_drp_responder #(.RD_LATENCY(RD_LAT), .EOC_PERIOD(EOC_P)) dut (
      .clk_100MHz       (clk_100MHz),
      .reset_n          (reset_n),
      .drp              (drp_if),
      .eoc_out          (eoc_out),
      .channel_out      (channel_out),
      .sample_valid     (sample_valid),
      .sample_ch        (sample_ch),
      .sample_data      (sample_data),
      .protocol_err_out (protocol_err_out),
      .dbg_state_out    (dbg_state_out)
   );

   // Clock and cycle counter.
   int cyc = 0;
   initial clk_100MHz = 1'b0;
   always #5 clk_100MHz = ~clk_100MHz;
   always @(posedge clk_100MHz) cyc <= cyc + 1;

   // Scoreboard state.
   logic [15:0] exp_q[$];
   int          exp_cyc_q[$];
   int          compared = 0;
   int          failed   = 0;
   vec_t        tab_a[8];
   vec_t        tab_c[8];

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      compared++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got 0x%04h, required 0x%04h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      reset_n            = 1'b0;
      drp_if.den_in      = 1'b0;
      drp_if.dwe_in      = 1'b0;
      drp_if.daddr_in    = 7'h00;
      drp_if.di_in       = 16'h0000;
      sample_valid       = 1'b0;
      sample_ch          = 2'd0;
      sample_data        = 12'h000;
      repeat (3) @(posedge clk_100MHz);
      @(negedge clk_100MHz);
      reset_n = 1'b1;
   endtask

   // Caller is just after a rising edge; den_in is held for exactly one cycle.
   task automatic drp_issue(input logic we, input logic [6:0] a, input logic [15:0] d,
                            input logic [15:0] e);
      drp_if.den_in   = 1'b1;
      drp_if.dwe_in   = we;
      drp_if.daddr_in = a;
      drp_if.di_in    = d;
      exp_q.push_back(e);
      exp_cyc_q.push_back(cyc + RD_LAT);
      @(posedge clk_100MHz);
      #1;
      drp_if.den_in = 1'b0;
      drp_if.dwe_in = 1'b0;
   endtask

   task automatic drp_wait_done();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 40) begin
         @(posedge clk_100MHz);
         n++;
      end
      if (exp_q.size() != 0) begin
         compared++;
         failed++;
         $display("FAIL drdy_timeout: %0d responses still outstanding, required 0", exp_q.size());
         exp_q.delete();
         exp_cyc_q.delete();
      end
   endtask

   task automatic drp_txn(input logic we, input logic [6:0] a, input logic [15:0] d,
                          input logic [15:0] e);
      @(posedge clk_100MHz);
      #1;
      drp_issue(we, a, d, e);
      drp_wait_done();
   endtask

   task automatic wait_eoc(input string name);
      int n;
      n = 0;
      while (n < 4 * EOC_P) begin
         @(negedge clk_100MHz);
         n++;
         if (eoc_out) break;
      end
      if (!eoc_out) begin
         compared++;
         failed++;
         $display("FAIL %s: eoc_out not seen within %0d cycles, required a pulse", name, 4 * EOC_P);
      end
   endtask

   initial begin
      logic [15:0] e;
      int          ec;

      tab_a[0] = '{1'b1, 7'h41, 16'hBEEF, 16'h0000};
      tab_a[1] = '{1'b0, 7'h41, 16'h0000, 16'hBEEF};
      tab_a[2] = '{1'b1, 7'h4F, 16'h1234, 16'h0000};
      tab_a[3] = '{1'b0, 7'h4F, 16'h0000, 16'h1234};
      tab_a[4] = '{1'b1, 7'h40, 16'hA5A5, 16'h0000};
      tab_a[5] = '{1'b0, 7'h40, 16'h0000, 16'hA5A5};
      tab_a[6] = '{1'b0, 7'h16, 16'h0000, 16'h0000};
      tab_a[7] = '{1'b0, 7'h1F, 16'h0000, 16'h0000};

      tab_c[0] = '{1'b1, 7'h16, 16'h1234, 16'h0000};
      tab_c[1] = '{1'b0, 7'h16, 16'h0000, 16'h0000};
      tab_c[2] = '{1'b0, 7'h05, 16'h0000, 16'h0000};
      tab_c[3] = '{1'b1, 7'h05, 16'hFFFF, 16'h0000};
      tab_c[4] = '{1'b0, 7'h05, 16'h0000, 16'h0000};
      tab_c[5] = '{1'b0, 7'h50, 16'h0000, 16'h0000};
      tab_c[6] = '{1'b0, 7'h4F, 16'h0000, 16'h1234};
      tab_c[7] = '{1'b0, 7'h41, 16'h0000, 16'hBEEF};

      // Response monitor: every drdy_out must match the head of the expected queue.
      fork
         forever begin
            @(negedge clk_100MHz);
            if (drp_if.drdy_out) begin
               if (exp_q.size() == 0) begin
                  compared++;
                  failed++;
                  $display("FAIL drdy_unexpected: drdy_out=1 do_out=0x%04h at cycle %0d, required no response",
                           drp_if.do_out, cyc);
               end else begin
                  e  = exp_q.pop_front();
                  ec = exp_cyc_q.pop_front();
                  check("do_out", drp_if.do_out, e);
                  compared++;
                  if (cyc != ec) begin
                     failed++;
                     $display("FAIL drdy_latency: drdy at cycle %0d, required cycle %0d", cyc, ec);
                  end
               end
            end
         end
      join_none

      // Reset values and first conversion timing.
      do_reset();
      reset_n = 1'b0;
      @(negedge clk_100MHz);
      check("rst_do", drp_if.do_out, 16'h0000);
      check("rst_drdy", {15'd0, drp_if.drdy_out}, 16'h0000);
      check("rst_busy", {15'd0, drp_if.drp_busy_out}, 16'h0000);
      check("rst_eoc", {15'd0, eoc_out}, 16'h0000);
      check("rst_channel", {11'd0, channel_out}, 16'h0016);
      check("rst_err", {15'd0, protocol_err_out}, 16'h0000);
      reset_n = 1'b1;
      repeat (EOC_P - 1) @(posedge clk_100MHz);
      #1;
      check("eoc_before_period", {15'd0, eoc_out}, 16'h0000);
      @(posedge clk_100MHz);
      #1;
      check("eoc_first", {15'd0, eoc_out}, 16'h0001);
      check("eoc_first_channel", {11'd0, channel_out}, 16'h0016);
      @(posedge clk_100MHz);
      #1;
      check("eoc_one_cycle", {15'd0, eoc_out}, 16'h0000);

      // Legal register traffic.
      for (int i = 0; i < 8; i++) begin
         drp_txn(tab_a[i].we, tab_a[i].addr, tab_a[i].di, tab_a[i].exp_do);
      end
      check("err_after_legal", {15'd0, protocol_err_out}, 16'h0000);

      // Second den_in two cycles after the first is dropped.
      @(posedge clk_100MHz);
      #1;
      drp_issue(1'b0, 7'h41, 16'h0000, 16'hBEEF);
      @(posedge clk_100MHz);
      #1;
      check("busy_in_wait", {15'd0, drp_if.drp_busy_out}, 16'h0001);
      drp_if.den_in   = 1'b1;
      drp_if.dwe_in   = 1'b1;
      drp_if.daddr_in = 7'h42;
      drp_if.di_in    = 16'h5555;
      @(posedge clk_100MHz);
      #1;
      drp_if.den_in = 1'b0;
      drp_if.dwe_in = 1'b0;
      drp_wait_done();
      repeat (10) @(posedge clk_100MHz);
      check("err_b2b", {15'd0, protocol_err_out}, {15'd0, ERR_EN});
      drp_txn(1'b0, 7'h42, 16'h0000, 16'h0000);

      // Read-only results, unmapped space.
      for (int i = 0; i < 8; i++) begin
         drp_txn(tab_c[i].we, tab_c[i].addr, tab_c[i].di, tab_c[i].exp_do);
      end
      check("err_after_illegal", {15'd0, protocol_err_out}, {15'd0, ERR_EN});

      // Conversion order, sample path and terminal-count bypass.
      do_reset();
      @(posedge clk_100MHz);
      #1;
      sample_valid = 1'b1;
      sample_ch    = 2'd2;
      sample_data  = 12'hABC;
      @(posedge clk_100MHz);
      #1;
      sample_valid = 1'b0;
      wait_eoc("eoc1");
      check("eoc1_channel", {11'd0, channel_out}, 16'h0016);
      wait_eoc("eoc2");
      check("eoc2_channel", {11'd0, channel_out}, 16'h0017);
      wait_eoc("eoc3");
      check("eoc3_channel", {11'd0, channel_out}, 16'h001E);
      drp_txn(1'b0, 7'h1E, 16'h0000, 16'hABC0);
      wait_eoc("eoc4");
      check("eoc4_channel", {11'd0, channel_out}, 16'h001F);
      repeat (EOC_P - 1) @(posedge clk_100MHz);
      #1;
      sample_valid = 1'b1;
      sample_ch    = 2'd0;
      sample_data  = 12'h7FF;
      drp_issue(1'b0, 7'h16, 16'h0000, 16'h0000);
      sample_valid = 1'b0;
      check("eoc5_pulse", {15'd0, eoc_out}, 16'h0001);
      check("eoc5_channel", {11'd0, channel_out}, 16'h0016);
      drp_wait_done();
      drp_txn(1'b0, 7'h16, 16'h0000, 16'h7FF0);

      // Reset during WAIT of a write: no response, no commit.
      @(posedge clk_100MHz);
      #1;
      drp_if.den_in   = 1'b1;
      drp_if.dwe_in   = 1'b1;
      drp_if.daddr_in = 7'h40;
      drp_if.di_in    = 16'hCAFE;
      @(posedge clk_100MHz);
      #1;
      drp_if.den_in = 1'b0;
      drp_if.dwe_in = 1'b0;
      @(posedge clk_100MHz);
      #1;
      reset_n = 1'b0;
      @(negedge clk_100MHz);
      check("midrst_busy", {15'd0, drp_if.drp_busy_out}, 16'h0000);
      check("midrst_drdy", {15'd0, drp_if.drdy_out}, 16'h0000);
      repeat (3) @(posedge clk_100MHz);
      @(negedge clk_100MHz);
      reset_n = 1'b1;
      @(posedge clk_100MHz);
      #1;
      check("midrst_channel", {11'd0, channel_out}, 16'h0016);
      repeat (4) @(posedge clk_100MHz);
      drp_txn(1'b0, 7'h40, 16'h0000, 16'h0000);
      repeat (5) @(posedge clk_100MHz);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
      $finish;
   end

endmodule

// File: doc/xadc_drp_responder.md
# xadc_drp_responder

DRP target that stands in for the XADC primitive on its dynamic reconfiguration port. It answers `den_in`/`dwe_in`/`daddr_in` transactions with `drdy_out`/`do_out` after a fixed latency. It holds a small register file and runs a conversion sequencer that fills the four auxiliary-channel result registers (XA1–XA4) from an external 12-bit sample source. It raises `eoc_out`/`channel_out` per conversion, so any existing DRP reader works unchanged against it, both in simulation and on boards without the XADC.

## Interface
- `RD_LATENCY`, 4: cycles from the `den_in` cycle to the `drdy_out` cycle; legal range 1..15.
- `EOC_PERIOD`, 100: cycles per conversion slot; legal range 2..65535.
- `clk_100MHz`  in  1  system clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `daddr_in`  in  7  DRP address, sampled when `den_in`=1.
- `den_in`  in  1  DRP enable, one-cycle strobe.
- `dwe_in`  in  1  write enable, sampled with `den_in`.
- `di_in`  in  16  write data, sampled with `den_in`.
- `do_out`  out  16  read data, valid only while `drdy_out`=1.
- `drdy_out`  out  1  one-cycle transaction-complete strobe.
- `drp_busy_out`  out  1  high while a transaction is outstanding.
- `eoc_out`  out  1  one-cycle end-of-conversion pulse.
- `channel_out`  out  5  channel of the most recent conversion, equal to address[4:0].
- `sample_valid`  in  1  qualifies `sample_ch`/`sample_data`.
- `sample_ch`  in  2  0..3 selects XA1..XA4.
- `sample_data`  in  12  unsigned ADC code.
- `protocol_err_out`  out  1  sticky protocol-error flag.

## Operation
- Register map:
  - 0x16, 0x17, 0x1E, 0x1F: result registers for XA1..XA4. Read-only; writes are ignored. Contents are `{code[11:0],4'h0}` (MSB-aligned).
  - 0x40..0x4F: sixteen read/write configuration registers.
  - All other addresses read 0x0000; writes to them are ignored.
- DRP FSM states:
  - IDLE: on `den_in`=1, capture addr, we and di. For reads, also capture the read data from the register value at that same cycle. Load the latency counter with `RD_LATENCY`-1 and go to WAIT, or go directly to RESP if `RD_LATENCY`=1.
  - WAIT: decrement the counter; at 0 go to RESP.
  - RESP: drive `drdy_out`=1 for one cycle and return to IDLE.
    - Read: `do_out` = captured data.
    - Write: `do_out` = 0x0000, and a write to 0x40..0x4F commits at this edge.
- `den_in` received in WAIT or RESP is dropped: no response and no state change.
- Shadow samples: `sample_valid` stores `sample_data` into `shadow[sample_ch]`. This happens in every cycle, independent of the DRP FSM.
- Sequencer:
  - A period counter counts 0..`EOC_PERIOD`-1.
  - At terminal count, `result[idx]` is loaded from `shadow[idx]`, `eoc_out` pulses, `channel_out` = `addr[idx]`[4:0], and `idx` advances 0→1→2→3→0.
  - Channel address order is 0x16, 0x17, 0x1E, 0x1F.
- Bypass: if `sample_valid` for channel `idx` coincides with terminal count, the new `sample_data` goes into the result register.

## Timing
- Reset values: `do_out`=0, `drdy_out`=0, `drp_busy_out`=0, `eoc_out`=0, `channel_out`=5'h16, `protocol_err_out`=0. All result, config and shadow registers reset to 0, as do `idx` and the period counter. FSM resets to IDLE.
- Read latency: `den_in` at cycle N gives `drdy_out` at cycle N+`RD_LATENCY`.
- Back-to-back: the next accepted `den_in` is at the earliest cycle N+`RD_LATENCY`+1.
- `drp_busy_out`: high from cycle N+1 through the RESP cycle inclusive.
- First `eoc_out`: `EOC_PERIOD` cycles after `reset_n` deasserts, i.e. on the `EOC_PERIOD`-th rising edge, for channel 0x16. Subsequent pulses follow every `EOC_PERIOD` cycles.
- Read coinciding with a result update: if `den_in` is in the same cycle as the terminal-count update of the addressed result register, the read returns the pre-update value.
- Reset mid-transaction: the FSM returns to IDLE immediately, with no `drdy_out` and no write commit.

## Configuration
- `XADC_RESP_PROTOCOL_CHECK_EN`:
  - Defined: `protocol_err_out` sets and stays set until reset when any of these occurs: `den_in` in WAIT or RESP; `den_in` to an unmapped address; a write to a result register.
  - Undefined: `protocol_err_out` is tied to 0, and the checker logic is absent.
  - Transaction behaviour is identical in both builds.

## Test plan
- `RD_LATENCY`=4: write 0xBEEF to 0x41 at cycle 10, then read 0x41. Required: write `drdy_out` at cycle 14 with `do_out`=0x0000; read returns 0xBEEF exactly 4 cycles after its `den_in`.
- `EOC_PERIOD`=8: apply `sample_valid` on ch 2 with code 0xABC, then wait for the third `eoc_out`. Required: `channel_out`=5'h1E on that pulse, and a read of 0x1E returns 0xABC0.
- `den_in` two cycles after a prior `den_in`. Required: only one `drdy_out`; `protocol_err_out`=1 with the macro defined and 0 without it.
- Write 0x1234 to 0x16, then read 0x16. Required: the read returns the unchanged conversion value; read of 0x05 returns 0x0000.
- Assert `reset_n`=0 during WAIT of a write to 0x40. Required: no `drdy_out`; after release, a read of 0x40 returns 0x0000 and `channel_out`=5'h16.
- `sample_valid` ch 0 with code 0x7FF in the terminal-count cycle of channel 0x16. Required: a read of 0x16 returns 0x7FF0.
